// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants: forwarding select encodings
// and the shadow-slot layouts tracked by the hazard/forwarding unit.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_slot_t;

  localparam ex_slot_t EX_SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};
  localparam wb_slot_t WB_SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0};

  // A slot only produces a forwardable value when it really writes a non-x0 register.
  function automatic logic is_producer(input logic valid, input logic reg_write,
                                       input logic [REG_W-1:0] rd);
    return valid && reg_write && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding comparator: picks the nearest older producer of rs
// as seen from the instruction about to enter EX.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_idex_prod,
  input  logic [REG_W-1:0] i_idex_rd,
  input  logic             i_exmem_prod,
  input  logic [REG_W-1:0] i_exmem_rd,
  output logic [1:0]       o_sel
);

  // ID/EX producer will sit in EX/MEM next cycle, so it wins over EX/MEM (-> MEM/WB).
  always_comb begin
    o_sel = FWD_REG;
    if (i_rs == REG_X0) begin
      o_sel = FWD_REG;
    end else if (i_idex_prod && (i_idex_rd == i_rs)) begin
      o_sel = FWD_EXMEM;
    end else if (i_exmem_prod && (i_exmem_rd == i_rs)) begin
      o_sel = FWD_MEMWB;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding select generator and load-use stall detector with a
// shadow ID/EX, EX/MEM, MEM/WB pipeline. Optional macro: HAZARD_WB_BYPASS_EN.
module hazard_forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic [1:0]       forward_a_sel,
  output logic [1:0]       forward_b_sel,
  output logic             load_use_stall,
  output logic             id_bypass_rs1,
  output logic             id_bypass_rs2
);

  ex_slot_t   r_idex;
  ex_slot_t   r_exmem;
  wb_slot_t   r_memwb;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  logic       w_idex_prod;
  logic       w_exmem_prod;
  logic       w_load_use;
  logic       w_bubble;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  ex_slot_t   w_id_slot;
  logic       w_unused;

  assign w_idex_prod  = is_producer(r_idex.valid, r_idex.reg_write, r_idex.rd);
  assign w_exmem_prod = is_producer(r_exmem.valid, r_exmem.reg_write, r_exmem.rd);

  // Any rs match against an in-flight load stalls; operand usage is not decoded.
  assign w_load_use = id_valid && r_idex.valid && r_idex.mem_read && (r_idex.rd != REG_X0)
                      && ((r_idex.rd == id_rs1) || (r_idex.rd == id_rs2)) && !ex_flush;
  assign w_bubble   = w_load_use || ex_flush || !id_valid;
  assign w_id_slot  = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  fwd_select u_fwd_a (
    .i_rs         (id_rs1),
    .i_idex_prod  (w_idex_prod),
    .i_idex_rd    (r_idex.rd),
    .i_exmem_prod (w_exmem_prod),
    .i_exmem_rd   (r_exmem.rd),
    .o_sel        (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_rs         (id_rs2),
    .i_idex_prod  (w_idex_prod),
    .i_idex_rd    (r_idex.rd),
    .i_exmem_prod (w_exmem_prod),
    .i_exmem_rd   (r_exmem.rd),
    .o_sel        (w_sel_b)
  );

  // Shadow pipeline advance; everything freezes while data memory is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex  <= EX_SLOT_EMPTY;
      r_exmem <= EX_SLOT_EMPTY;
      r_memwb <= WB_SLOT_EMPTY;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else if (!mem_stall) begin
      r_memwb <= '{valid: r_exmem.valid, rd: r_exmem.rd, reg_write: r_exmem.reg_write};
      r_exmem <= r_idex;
      if (w_bubble) begin
        r_idex  <= EX_SLOT_EMPTY;
        r_fwd_a <= FWD_REG;
        r_fwd_b <= FWD_REG;
      end else begin
        r_idex  <= w_id_slot;
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end
    end
  end

  assign forward_a_sel  = r_fwd_a;
  assign forward_b_sel  = r_fwd_b;
  assign load_use_stall = w_load_use;

`ifdef HAZARD_WB_BYPASS_EN
  logic w_memwb_prod;
  assign w_memwb_prod  = is_producer(r_memwb.valid, r_memwb.reg_write, r_memwb.rd);
  assign id_bypass_rs1 = w_memwb_prod && (r_memwb.rd == id_rs1) && (id_rs1 != REG_X0);
  assign id_bypass_rs2 = w_memwb_prod && (r_memwb.rd == id_rs2) && (id_rs2 != REG_X0);
`else
  assign id_bypass_rs1 = 1'b0;
  assign id_bypass_rs2 = 1'b0;
`endif

  // Shadow fields that have no consumer in some builds are kept for debug visibility.
  assign w_unused = ^{r_exmem.mem_read, r_memwb};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit; bypass expectations
// follow whether HAZARD_WB_BYPASS_EN is defined for the build.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, ex_flush, mem_stall;
  logic [1:0] forward_a_sel, forward_b_sel;
  logic       load_use_stall, id_bypass_rs1, id_bypass_rs2;

  int errors = 0;
  int checks = 0;

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic BYP_EXP = 1'b1;
`else
  localparam logic BYP_EXP = 1'b0;
`endif

  hazard_forward_unit dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .ex_flush       (ex_flush),
    .mem_stall      (mem_stall),
    .forward_a_sel  (forward_a_sel),
    .forward_b_sel  (forward_b_sel),
    .load_use_stall (load_use_stall),
    .id_bypass_rs1  (id_bypass_rs1),
    .id_bypass_rs2  (id_bypass_rs2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_flush = 1'b0; mem_stall = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++; if (forward_a_sel !== 2'b00) begin errors++; $display("FAIL reset_a: got %b want 00", forward_a_sel); end
    checks++; if (forward_b_sel !== 2'b00) begin errors++; $display("FAIL reset_b: got %b want 00", forward_b_sel); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", load_use_stall); end
    checks++; if ({id_bypass_rs1, id_bypass_rs2} !== 2'b00) begin errors++; $display("FAIL reset_bypass: got %b%b want 00", id_bypass_rs1, id_bypass_rs2); end
  endtask

  task automatic test_alu_forward();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    drive(1'b1, 5'd5, 5'd3, 5'd10, 1'b1, 1'b0);  // reads x5 on rs1
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", load_use_stall); end
    tick();
    checks++; if (forward_a_sel !== 2'b10) begin errors++; $display("FAIL alu_fwd_a: got %b want 10", forward_a_sel); end
    checks++; if (forward_b_sel !== 2'b00) begin errors++; $display("FAIL alu_fwd_b: got %b want 00", forward_b_sel); end
    drive(1'b1, 5'd0, 5'd5, 5'd11, 1'b1, 1'b0);  // x5 now one stage further
    tick();
    checks++; if (forward_a_sel !== 2'b00) begin errors++; $display("FAIL alu2_fwd_a: got %b want 00", forward_a_sel); end
    checks++; if (forward_b_sel !== 2'b01) begin errors++; $display("FAIL alu2_fwd_b: got %b want 01", forward_b_sel); end
  endtask

  task automatic test_load_use();
    drain();
    drive(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1);   // lw x6
    tick();
    drive(1'b1, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0);   // uses x6 on rs2
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", load_use_stall); end
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0000) begin errors++; $display("FAIL lu_bubble_sel: got %b want 0000", {forward_a_sel, forward_b_sel}); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b want 0", load_use_stall); end
    tick();
    checks++; if (forward_b_sel !== 2'b01) begin errors++; $display("FAIL lu_fwd_b: got %b want 01", forward_b_sel); end
    checks++; if (forward_a_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd_a: got %b want 00", forward_a_sel); end
  endtask

  task automatic test_x0();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", load_use_stall); end
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0000) begin errors++; $display("FAIL x0_sel: got %b want 0000", {forward_a_sel, forward_b_sel}); end
  endtask

  task automatic test_priority();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b1010) begin errors++; $display("FAIL prio_sel: got %b want 1010", {forward_a_sel, forward_b_sel}); end
  endtask

  task automatic test_back_to_back();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);   // x8 = ...
    tick();
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);   // x9 = f(x8)
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b1000) begin errors++; $display("FAIL b2b_mid: got %b want 1000", {forward_a_sel, forward_b_sel}); end
    drive(1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0);  // user of x9 and x8
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b1001) begin errors++; $display("FAIL b2b_user: got %b want 1001", {forward_a_sel, forward_b_sel}); end
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1);   // lw x6
    tick();
    ex_flush = 1'b1;
    drive(1'b1, 5'd0, 5'd6, 5'd11, 1'b1, 1'b0);  // killed: would be load-use
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", load_use_stall); end
    tick();
    ex_flush = 1'b0;
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0000) begin errors++; $display("FAIL flush_bubble: got %b want 0000", {forward_a_sel, forward_b_sel}); end
    drive(1'b1, 5'd11, 5'd6, 5'd12, 1'b1, 1'b0); // x11 must not forward from killed op
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %b want 0", load_use_stall); end
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0001) begin errors++; $display("FAIL flush_after_sel: got %b want 0001", {forward_a_sel, forward_b_sel}); end
  endtask

  task automatic test_mem_stall();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd12, 5'd14, 1'b1, 1'b0);
    mem_stall = 1'b1; ex_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({forward_a_sel, forward_b_sel} !== 4'b1000) begin errors++; $display("FAIL mstall_hold%0d: got %b want 1000", i, {forward_a_sel, forward_b_sel}); end
    end
    mem_stall = 1'b0; ex_flush = 1'b0;
    tick();
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0001) begin errors++; $display("FAIL mstall_release: got %b want 0001", {forward_a_sel, forward_b_sel}); end
    // load-use is still reported while frozen
    drain();
    drive(1'b1, 5'd1, 5'd0, 5'd15, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd15, 5'd0, 5'd16, 1'b1, 1'b0);
    mem_stall = 1'b1;
    tick();
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL mstall_lu: got %b want 1", load_use_stall); end
    mem_stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0);
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", load_use_stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", load_use_stall); end
    checks++; if ({forward_a_sel, forward_b_sel} !== 4'b0000) begin errors++; $display("FAIL rst_mid_sel: got %b want 0000", {forward_a_sel, forward_b_sel}); end
  endtask

  task automatic test_wb_bypass();
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    drive(1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b0);
    checks++; if (id_bypass_rs1 !== BYP_EXP) begin errors++; $display("FAIL byp_rs1: got %b want %b", id_bypass_rs1, BYP_EXP); end
    checks++; if (id_bypass_rs2 !== 1'b0) begin errors++; $display("FAIL byp_rs2_nomatch: got %b want 0", id_bypass_rs2); end
    drive(1'b1, 5'd3, 5'd9, 5'd4, 1'b1, 1'b0);
    checks++; if ({id_bypass_rs1, id_bypass_rs2} !== {1'b0, BYP_EXP}) begin errors++; $display("FAIL byp_rs2: got %b%b want 0%b", id_bypass_rs1, id_bypass_rs2, BYP_EXP); end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_x0();
    test_priority();
    test_back_to_back();
    test_flush();
    test_mem_stall();
    test_reset_mid_stall();
    test_wb_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller feeding the EX-stage operand forwarding muxes of the 5-stage RISC-V core. It keeps a shadow copy of destination-register metadata for the ID/EX, EX/MEM and MEM/WB stages and computes registered 2-bit forwarding selects for EX operands A and B. It also detects load-use hazards, driving the stall and bubble controls for IF/ID and ID/EX, and applies branch flushes to its shadow pipeline.

## Interface
- No parameters; register index width fixed at 5, XLEN-independent.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  instruction present in ID
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_rd  in  5  destination register of instruction in ID
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_flush  in  1  branch/jump resolved taken in EX; kill instruction in ID
- mem_stall  in  1  data memory wait; freeze whole pipeline
- forward_a_sel, forward_b_sel  out  2  registered selects for EX operands: 00 regfile, 01 MEM/WB, 10 EX/MEM
- load_use_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- id_bypass_rs1, id_bypass_rs2  out  1  WB write targets the ID source this cycle (see Configuration)

## Operation
- Shadow slots: IDEX {valid, rd, reg_write, mem_read}, EXMEM {valid, rd, reg_write, mem_read}, MEMWB {valid, rd, reg_write}. A slot is a producer only if valid && reg_write && rd != 0.
- Advance (mem_stall=0): MEMWB<=EXMEM, EXMEM<=IDEX, IDEX<=ID fields, or a bubble (valid=0) if load_use_stall or ex_flush or !id_valid.
- Select computation at advance, per operand rs (rs1→A, rs2→B), with the ID instruction entering EX:
  - rs==0 → 00.
  - IDEX producer with rd==rs → 10 (it becomes EX/MEM).
  - else EXMEM producer with rd==rs → 01 (it becomes MEM/WB).
  - else → 00. EX/MEM match has priority over MEM/WB.
  - Bubble entering EX → both selects 00.
- load_use_stall (combinational) = id_valid && IDEX.valid && IDEX.mem_read && IDEX.rd!=0 && (IDEX.rd==id_rs1 || IDEX.rd==id_rs2) && !ex_flush. Operand-usage is not decoded; any rs match stalls.
- Flush beats load-use: ex_flush=1 forces load_use_stall=0 and bubble into IDEX.
- mem_stall=1: all slots and selects hold; ex_flush ignored (upstream holds it until advance); load_use_stall still reported but causes no state change.

## Timing
- Reset: all slots invalid, forward_a_sel=forward_b_sel=00, load_use_stall=0, id_bypass_*=0.
- Selects valid in the cycle the instruction occupies EX, launched from a register (no comb path from ID inputs).
- load_use_stall is same-cycle combinational from ID inputs and registered state; it lasts exactly one cycle per load-use pair (absent mem_stall). The consumer then gets select 01.
- Back-to-back producer chain (ALU→ALU→user): user receives 10 for the nearest producer.
- Reset asserted mid-stall clears slots; the next cycle shows no stall.

## Configuration
- HAZARD_WB_BYPASS_EN defined: id_bypass_rsN = MEMWB producer && MEMWB.rd==id_rsN (rs!=0), combinational, for regfile read-after-write in the same cycle.
- Undefined: id_bypass_rs1/rs2 tied 0; regfile must be write-first.

## Structure
- Shared package/header pipe_ctrl_pkg: FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10; shadow-slot field widths.
- One sub-module fwd_select: per-operand comparator (rs, IDEX slot, EXMEM slot → 2-bit select), instantiated twice.

## Test plan
- add x5 in ID/EX, ID reads rs1=x5 → after edge forward_a_sel=10, forward_b_sel=00.
- lw x6, then use rs2=x6 next → load_use_stall=1 for one cycle, bubble in EX, then forward_b_sel=01.
- Write x0 by the producer, consumer reads x0 → selects 00, no stall.
- x7 written by both EXMEM and IDEX producers, consumer reads x7 → 10 (priority).
- Load-use coincident with ex_flush → stall=0, bubble; mem_stall=1 for 3 cycles → selects and slots unchanged.
- With HAZARD_WB_BYPASS_EN, MEMWB rd=x9 and id_rs1=x9 → id_bypass_rs1=1; without the macro → 0.
